osc_freq_meter: RTL
===================

Name: osc_freq_meter

Overview:
- Digital frequency meter for the on-die ring-oscillator array, parametrised in channel count.
- Counts rising edges of one selected oscillator channel (A) over a programmable gate window of clk cycles.
- Difference mode counts a second channel (B) in the same window and reports signed A−B, so two nominally close oscillators can be compared directly.
- Sits between the oscillator outputs (already divided below clk/2) and the user I/O readout logic; supports single-shot and continuous measurement.

Parameters:
- N_CH, 4, number of oscillator input channels (≥2)
- CNT_W, 16, edge-counter width per channel path
- GATE_W, 16, width of gate-window length input
- SYNC_STAGES, 2, synchroniser depth per channel (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- osc_in  in  N_CH  asynchronous oscillator signals, each < clk/2
- start  in  1  request a measurement (level, sampled in IDLE)
- continuous  in  1  re-arm automatically after each window
- diff_mode  in  1  also count channel B and compute A−B
- sel_a  in  $clog2(N_CH)  channel A index
- sel_b  in  $clog2(N_CH)  channel B index
- gate_cycles  in  GATE_W  window length in clk cycles; 0 is treated as 1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when results update
- count_a  out  CNT_W  latched edge count, channel A
- count_b  out  CNT_W  latched edge count, channel B (0 when diff_mode was 0)
- diff  out  CNT_W+1  signed count_a − count_b
- overflow  out  1  latched: either counter saturated in the last window

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: all outputs 0, FSM to IDLE, counters and synchronisers cleared. This applies mid-window too; the partial result is discarded and no done pulse is issued.
- Input synchronisation: every channel passes through SYNC_STAGES flops. A rising edge is detected as last stage 1 with previous value 0. One increment per detected edge.
- FSM states: IDLE, ARM, GATE, LATCH.
- IDLE:
  - On a clk edge with start=1, capture sel_a, sel_b, diff_mode, gate_cycles and continuous into shadow registers.
  - Clear the working counters and go to ARM.
  - Inputs changed later have no effect until the next capture.
- ARM: lasts exactly SYNC_STAGES+1 cycles. Detected edges are ignored, which flushes stale synchroniser contents. Then go to GATE.
- GATE:
  - Lasts exactly max(gate_cycles,1) cycles.
  - Edge on the shadow sel_a channel increments cnt_a.
  - If shadow diff_mode=1, an edge on the shadow sel_b channel increments cnt_b.
  - sel_a==sel_b is legal; both counters then count identically and diff=0.
- Saturation: a counter at 2^CNT_W−1 holds its value and sets an internal ovf flag.
- LATCH (1 cycle):
  - count_a and count_b take the working counters; count_b takes 0 if diff_mode=0.
  - diff = zero-extended count_a − zero-extended count_b; overflow = ovf.
  - done=1 for this cycle only.
  - Next state: ARM if the live continuous input is 1 (shadow registers are re-captured from the live inputs and counters cleared), else IDLE.
- Latency: start seen at edge k → done high in cycle k+SYNC_STAGES+2+max(G,1)+1. Outputs update in the same cycle as done.
- Outputs hold their last latched value until the next LATCH or reset.
- start during busy is ignored.
- Deasserting continuous mid-window lets the current window complete with done, then the FSM returns to IDLE.
- busy is low only in IDLE. In IDLE with start=1, busy rises the next cycle.

Decomposition:
- Package osc_meter_pkg holds:
  - state enum {IDLE, ARM, GATE, LATCH}
  - localparam SEL_W = $clog2(N_CH)
  - helper function for the gate=0→1 clamp
- Sub-module osc_edge_sync: one channel, parameter SYNC_STAGES; ports clk, rst_n, async_in, rise_pulse. Instantiate N_CH times via generate.
- Top module contains the select muxes, FSM, counters and latching.

Test Plan:
- Single-shot, SYNC_STAGES=2, ch0 square wave period 10 clk, gate_cycles=100, sel_a=0 → done exactly 106 cycles after start; count_a=10, count_b=0, diff=10, overflow=0.
- diff_mode=1, ch1 period 10, ch2 period 12, gate=120, sel_a=1, sel_b=2 → count_a=12, count_b=10, diff=+2. Swap selects → diff=−2 (all ones in bits CNT_W..1, LSB 0).
- CNT_W=4, ch0 period 4, gate=100 → count_a=15 (saturated), overflow=1. Next window with period 10, gate=50 → count_a=5, overflow=0.
- continuous=1, gate=20, ch3 period 5 → done pulses every 24 cycles, each with count_a=4. Drop continuous mid-window → exactly one more done, then busy=0.
- gate_cycles=0 → behaves as gate=1: done 7 cycles after start. start pulsed while busy → no extra window.
- rst_n low for 1 cycle mid-GATE → next cycle all outputs 0, busy=0, no done pulse; a new start gives correct counts.

Source files
------------

// File: rtl/osc_freq_meter_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter.
// Imported by the meter top and available to any readout logic that decodes its state.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int DEF_N_CH = 4;
  localparam int SEL_W    = $clog2(DEF_N_CH);

  // A zero-length window is meaningless, so it is stretched to one cycle.
  function automatic logic [31:0] gate_len_clamp(input logic [31:0] gate);
    if (gate == 32'd0) begin
      return 32'd1;
    end else begin
      return gate;
    end
  endfunction

endpackage

// File: rtl/osc_freq_meter_if.sv
// Control/result bundle between the oscillator array, the frequency meter and the readout logic.
interface osc_freq_meter_if #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
);
  localparam int SW = $clog2(N_CH);

  logic [N_CH-1:0]   osc_in;
  logic              start;
  logic              continuous;
  logic              diff_mode;
  logic [SW-1:0]     sel_a;
  logic [SW-1:0]     sel_b;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;
  logic [CNT_W:0]    diff;
  logic              overflow;

  modport slave (
    input  osc_in, start, continuous, diff_mode, sel_a, sel_b, gate_cycles,
    output busy, done, count_a, count_b, diff, overflow
  );

  modport master (
    output osc_in, start, continuous, diff_mode, sel_a, sel_b, gate_cycles,
    input  busy, done, count_a, count_b, diff, overflow
  );
endinterface

// File: rtl/osc_edge_sync.sv
// One oscillator channel: multi-flop synchroniser followed by a rising-edge detector.
module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the asynchronous input through the synchroniser and keep the last stage's previous value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/osc_freq_meter.sv
// Gated edge counter for the ring-oscillator array: counts channel A (and optionally B)
// over a programmable window and latches A, B and the signed difference.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  osc_freq_meter_if.slave bus
);

  localparam int SW = $clog2(N_CH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [GATE_W-1:0] ARM_LAST  = GATE_W'(SYNC_STAGES);

  logic [N_CH-1:0]   w_rise;
  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_capture;
  logic [GATE_W-1:0] r_tcnt;
  logic [GATE_W-1:0] r_gate_len;
  logic [GATE_W-1:0] w_gate_clamp;
  logic [SW-1:0]     r_sel_a;
  logic [SW-1:0]     r_sel_b;
  logic              r_diff_mode;
  logic [CNT_W-1:0]  r_cnt_a;
  logic [CNT_W-1:0]  r_cnt_b;
  logic [CNT_W-1:0]  w_cnt_b_eff;
  logic              r_ovf;
  logic              w_rise_a;
  logic              w_rise_b;

  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_count_a;
  logic [CNT_W-1:0]  r_count_b;
  logic [CNT_W:0]    r_diff;
  logic              r_overflow;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    osc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (bus.osc_in[g]),
      .rise_pulse(w_rise[g])
    );
  end

  assign w_gate_clamp = GATE_W'(gate_len_clamp(32'(bus.gate_cycles)));
  assign w_rise_a     = w_rise[r_sel_a];
  assign w_rise_b     = r_diff_mode & w_rise[r_sel_b];
  assign w_cnt_b_eff  = r_diff_mode ? r_cnt_b : CNT_ZERO;

  // Next-state logic; capture happens on leaving IDLE and on a continuous re-arm.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ARM;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ARM: begin
        if (r_tcnt == ARM_LAST) begin
          w_state_nxt = GATE;
        end else begin
          w_state_nxt = ARM;
        end
      end
      GATE: begin
        if (r_tcnt == (r_gate_len - GATE_ONE)) begin
          w_state_nxt = LATCH;
        end else begin
          w_state_nxt = GATE;
        end
      end
      LATCH: begin
        if (bus.continuous) begin
          w_state_nxt = ARM;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register plus the per-state cycle timer, which restarts on every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tcnt  <= GATE_ZERO;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
        r_tcnt <= GATE_ZERO;
      end else begin
        r_tcnt <= r_tcnt + GATE_ONE;
      end
    end
  end

  // Shadow copies of the measurement setup, so live inputs can change during a window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_a     <= {SW{1'b0}};
      r_sel_b     <= {SW{1'b0}};
      r_diff_mode <= 1'b0;
      r_gate_len  <= GATE_ONE;
    end else if (w_capture) begin
      r_sel_a     <= bus.sel_a;
      r_sel_b     <= bus.sel_b;
      r_diff_mode <= bus.diff_mode;
      r_gate_len  <= w_gate_clamp;
    end else begin
      r_gate_len  <= r_gate_len;
    end
  end

  // Saturating working counters; edges are only counted inside the gate window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_a <= CNT_ZERO;
      r_cnt_b <= CNT_ZERO;
      r_ovf   <= 1'b0;
    end else if (w_capture) begin
      r_cnt_a <= CNT_ZERO;
      r_cnt_b <= CNT_ZERO;
      r_ovf   <= 1'b0;
    end else if (r_state == GATE) begin
      if (w_rise_a) begin
        if (r_cnt_a == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt_a <= r_cnt_a + CNT_ONE;
        end
      end
      if (w_rise_b) begin
        if (r_cnt_b == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt_b <= r_cnt_b + CNT_ONE;
        end
      end
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Result registers: loaded once per window as the FSM leaves LATCH, so done aligns with new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count_a  <= CNT_ZERO;
      r_count_b  <= CNT_ZERO;
      r_diff     <= {(CNT_W+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      if (r_state == LATCH) begin
        r_done     <= 1'b1;
        r_count_a  <= r_cnt_a;
        r_count_b  <= w_cnt_b_eff;
        r_diff     <= {1'b0, r_cnt_a} - {1'b0, w_cnt_b_eff};
        r_overflow <= r_ovf;
      end else begin
        r_done <= 1'b0;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count_a  = r_count_a;
  assign bus.count_b  = r_count_b;
  assign bus.diff     = r_diff;
  assign bus.overflow = r_overflow;

endmodule
